// File: rtl/mux_16x1.sv
// Registered 16-to-1 single-bit multiplexer.
// A balanced four-level tree of 2:1 cells picks D[S]. A single flop then
// presents the selected bit on Y one clock later.

// Basic 2:1 cell used at every level of the tree; sel = 1 picks the upper input
module mux2_cell (
  input  logic lo,
  input  logic hi,
  input  logic sel,
  output logic y
);

  // Purely combinational selection between the lower and upper candidate
  always_comb begin
    y = sel ? hi : lo;
  end

endmodule

module mux_16x1 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] D,
  input  logic [3:0]  S,
  output logic        Y
);

  // Intermediate tree nodes; each level halves the candidate count
  logic [7:0] level1;
  logic [3:0] level2;
  logic [1:0] level3;
  logic       level4;

  // Level 1: S[0] chooses within adjacent pairs (D[1],D[0]) .. (D[15],D[14])
  for (genvar i = 0; i < 8; i++) begin : g_level1
    mux2_cell u_cell (
      .lo  (D[2*i]),
      .hi  (D[2*i+1]),
      .sel (S[0]),
      .y   (level1[i])
    );
  end

  // Level 2: S[1] chooses between neighbouring level-1 results
  for (genvar i = 0; i < 4; i++) begin : g_level2
    mux2_cell u_cell (
      .lo  (level1[2*i]),
      .hi  (level1[2*i+1]),
      .sel (S[1]),
      .y   (level2[i])
    );
  end

  // Level 3: S[2] chooses between neighbouring level-2 results
  for (genvar i = 0; i < 2; i++) begin : g_level3
    mux2_cell u_cell (
      .lo  (level2[2*i]),
      .hi  (level2[2*i+1]),
      .sel (S[2]),
      .y   (level3[i])
    );
  end

  // Level 4: S[3] picks between the lower and upper halves of the word
  mux2_cell u_level4 (
    .lo  (level3[0]),
    .hi  (level3[1]),
    .sel (S[3]),
    .y   (level4)
  );

  // Output register: synchronous active-low reset clears Y, otherwise load the tree result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Y <= 1'b0;
    end else begin
      Y <= level4;
    end
  end

endmodule

// File: tb/tb_mux_16x1.sv
// Directed and random self-checking bench for the registered 16:1 mux.
module tb_mux_16x1;

  logic        clk;
  logic        rst_n;
  logic [15:0] D;
  logic [3:0]  S;
  logic        Y;

  int pass_count;
  int total_count;

  localparam logic [15:0] PATTERN = 16'b1001_1010_0110_1001;

  mux_16x1 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .D     (D),
    .S     (S),
    .Y     (Y)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one set of inputs, clock them in, then settle just after the edge
  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] s, input logic r);
    D     = d;
    S     = s;
    rst_n = r;
    @(posedge clk);
    #1;
  endtask

  // Compare Y against a bench-computed expectation
  task automatic checkOutput(input string tag, input logic expected);
    total_count++;
    assert (Y === expected) begin
      pass_count++;
    end else begin
      $error("[TB] FAIL %s: Y=%b expected %b", tag, Y, expected);
    end
  endtask

  // Reference model: shift-and-mask rather than a tree
  function automatic logic model(input logic [15:0] d, input logic [3:0] s, input logic r);
    logic [15:0] shifted;
    shifted = d >> s;
    return r ? shifted[0] : 1'b0;
  endfunction

  initial begin
    logic [15:0] rd;
    logic [3:0]  rs;
    logic        rr;
    logic        exp_y;

    pass_count  = 0;
    total_count = 0;
    D     = 16'h0000;
    S     = 4'd0;
    rst_n = 1'b0;

    // Reset held for two edges with all data bits high
    applyStimulus(16'hFFFF, 4'd0, 1'b0);
    checkOutput("reset_edge1", 1'b0);
    applyStimulus(16'hFFFF, 4'd0, 1'b0);
    checkOutput("reset_edge2", 1'b0);
    applyStimulus(16'hFFFF, 4'd0, 1'b1);
    checkOutput("reset_release", 1'b1);

    // Selection sweep over the fixed pattern
    applyStimulus(PATTERN, 4'd1, 1'b1);
    checkOutput("sweep_s1", 1'b0);
    applyStimulus(PATTERN, 4'd5, 1'b1);
    checkOutput("sweep_s5", 1'b1);
    applyStimulus(PATTERN, 4'd9, 1'b1);
    checkOutput("sweep_s9", 1'b1);
    applyStimulus(PATTERN, 4'd6, 1'b1);
    checkOutput("sweep_s6", 1'b1);
    applyStimulus(PATTERN, 4'd11, 1'b1);
    checkOutput("sweep_s11", 1'b1);
    applyStimulus(PATTERN, 4'd4, 1'b1);
    checkOutput("sweep_s4", 1'b0);
    applyStimulus(PATTERN, 4'd10, 1'b1);
    checkOutput("sweep_s10", 1'b0);

    // Exhaustive one-hot: only the matching select returns 1
    for (int i = 0; i < 16; i++) begin
      for (int s = 0; s < 16; s++) begin
        applyStimulus(16'(1) << i, 4'(s), 1'b1);
        checkOutput($sformatf("onehot_d%0d_s%0d", i, s), (i == s) ? 1'b1 : 1'b0);
      end
    end

    // Latency and glitch: changes between edges must not reach Y
    applyStimulus(16'h0008, 4'd3, 1'b1);
    checkOutput("glitch_load1", 1'b1);
    D = 16'h0000;
    #2;
    checkOutput("glitch_hold_d3_low", 1'b1);
    D = 16'hFFF7;
    #1;
    checkOutput("glitch_hold_others", 1'b1);
    D = 16'h0008;
    #1;
    D = 16'hFFF7;
    @(posedge clk);
    #1;
    checkOutput("glitch_sampled_low", 1'b0);
    D = 16'h0008;
    #3;
    checkOutput("glitch_hold_low", 1'b0);
    applyStimulus(16'h0008, 4'd3, 1'b1);
    checkOutput("glitch_load2", 1'b1);
    applyStimulus(16'hFFFF, 4'd3, 1'b1);
    checkOutput("glitch_others_high", 1'b1);

    // Mid-stream reset
    applyStimulus(16'h0001, 4'd0, 1'b1);
    checkOutput("mid_pre", 1'b1);
    applyStimulus(16'h0001, 4'd0, 1'b0);
    checkOutput("mid_reset", 1'b0);
    applyStimulus(16'h0001, 4'd0, 1'b1);
    checkOutput("mid_release", 1'b1);

    // Random traffic with occasional reset
    for (int n = 0; n < 1000; n++) begin
      rd = 16'($urandom);
      rs = 4'($urandom_range(0, 15));
      rr = ($urandom_range(0, 15) != 0);
      exp_y = model(rd, rs, rr);
      applyStimulus(rd, rs, rr);
      checkOutput($sformatf("random_%0d_d%04h_s%0d_r%0b", n, rd, rs, rr), exp_y);
    end

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
